// File: rtl/mips_mdu_pkg.sv
// mips_mdu_pkg: shared constants and types for the multiply/divide unit.
//   - 3-bit op encodings for MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   - default multi-cycle latencies
//   - FSM state type and op classification helpers
package mips_mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_multi_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mips_mdu_calc.sv
// mips_mdu_calc: combinational arithmetic core of the multiply/divide unit.
//   op_i        operation select (MULT/MULTU/DIV/DIVU; others give 0)
//   a_i, b_i    rs / rt operands
//   result_o    {hi, lo}: product, or {remainder, quotient}
//   div_zero_o  divide op with b_i == 0 (commit must be suppressed)
module mips_mdu_calc
    import mips_mdu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    always_comb begin
        // Low 64 bits of the product of sign-extended operands equal the
        // signed 32x32 product, so no signed casts are needed.
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u = {32'b0, a_i} * {32'b0, b_i};

        // Divisor forced non-zero so the datapath never divides by zero;
        // the result is discarded at commit anyway.
        b_safe = (b_i == 32'd0) ? 32'd1 : b_i;

        q_u = a_i / b_safe;
        r_u = a_i % b_safe;

        // Signed divide on magnitudes: quotient truncates toward zero,
        // remainder follows the dividend's sign. 0x80000000 / -1 falls out
        // as magnitude 0x80000000 negated = 0x80000000, remainder 0.
        a_mag = a_i[31] ? (32'd0 - a_i) : a_i;
        b_mag = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        q_s   = (a_i[31] ^ b_safe[31]) ? (32'd0 - q_mag) : q_mag;
        r_s   = a_i[31] ? (32'd0 - r_mag) : r_mag;

        div_zero_o = is_div_op(op_i) && (b_i == 32'd0);

        case (op_i)
            MDU_MULT:  result_o = prod_s;
            MDU_MULTU: result_o = prod_u;
            MDU_DIV:   result_o = {r_s, q_s};
            MDU_DIVU:  result_o = {r_u, q_u};
            default:   result_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/mips_mdu.sv
// mips_mdu: E-stage multiply/divide unit with HI/LO registers.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       one-cycle pulse: mult/div/mt instruction valid in E
//   op          MDU_* operation code
//   A, B        forwarded rs / rt operands
//   busy        multi-cycle op in flight (hazard unit stalls MD-class in D)
//   HI, LO      committed HI/LO registers
// The result is computed at the start edge and held as pending; it is
// committed to HI/LO on the last busy cycle's edge, so the new values are
// visible on the first cycle busy is low.
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;
    logic             pend_dz_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;

    logic [63:0]      calc_res;
    logic             calc_dz;
    logic [CNT_W-1:0] cnt_d;

    mips_mdu_calc u_calc (
        .op_i       (op),
        .a_i        (A),
        .b_i        (B),
        .result_o   (calc_res),
        .div_zero_o (calc_dz)
    );

    assign cnt_d = cnt_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_dz_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && is_multi_op(op)) begin
                        pend_hi_q <= calc_res[63:32];
                        pend_lo_q <= calc_res[31:0];
                        pend_dz_q <= calc_dz;
                        cnt_q     <= is_div_op(op) ? CNT_W'(DIV_CYCLES)
                                                   : CNT_W'(MULT_CYCLES);
                        busy_q    <= 1'b1;
                        state_q   <= ST_RUN;
                    end else if (start && op == MDU_MTHI) begin
                        hi_q <= A;
                    end else if (start && op == MDU_MTLO) begin
                        lo_q <= A;
                    end
                end
                ST_RUN: begin
                    // start is ignored here: the hazard unit never issues
                    // an MD-class instruction while busy.
                    if (cnt_q == CNT_W'(1)) begin
                        if (!pend_dz_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and holds the HI/LO architectural registers.
- It is the producer side of the multi-cycle stall interface: while the unit is `start`-ed or `busy`, the hazard unit stalls any D-stage instruction that needs it (mult/div/mfhi/mflo/mthi/mtlo).
- mtlo/mthi write directly; mfhi/mflo read the HI/LO outputs combinationally.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a MULT/MULTU start (≥1).
- DIV_CYCLES, 10, cycles busy stays high after a DIV/DIVU start (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage mult/div/mt instruction valid this cycle; one-cycle pulse.
- op  in  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO (encodings in macro.v).
- A  in  32  rs operand, forwarded E-stage value.
- B  in  32  rt operand, forwarded E-stage value.
- busy  out  1  multi-cycle operation in flight.
- HI  out  32  committed HI register.
- LO  out  32  committed LO register.

Behaviour:
- Reset: on a clk edge with reset=1, busy=0, HI=0, LO=0, counter=0, pending results=0.
  - Reset overrides start.
  - Reset mid-operation aborts it; HI/LO do not receive the in-flight result.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, down-counter cnt).
- IDLE + start + op∈{MULT,MULTU,DIV,DIVU}:
  - Capture the result into pending hi/lo at the edge.
  - Set cnt = MULT_CYCLES or DIV_CYCLES; go to RUN.
  - busy rises the cycle after start.
- RUN: each edge decrements cnt.
  - On the edge where cnt==1: HI/LO ← pending, busy ← 0, go to IDLE.
  - busy is therefore high for exactly N cycles. New HI/LO are visible on the first cycle busy is low.
- IDLE + start + MTHI: HI ← A at the edge; busy stays 0. MTLO likewise writes LO ← A.
- start while busy=1 (any op): ignored. The hazard unit guarantees this does not happen; the assertion in the bench must never fire.
- start with an undefined op: no effect.
- Arithmetic:
  - MULT: {HI,LO} = $signed(A)·$signed(B), full 64-bit result.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend (A).
  - DIVU: unsigned quotient in LO, remainder in HI.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0): the operation still runs DIV_CYCLES with busy high, but HI/LO are left unchanged at commit.
- Stall contract (consumed by the hazard unit): any MD-class instruction in D stalls when (E start && E is MD) || busy.
- The unit does not flush itself. The pipeline guarantees an aborted instruction never asserts start.

Decomposition:
- Shared constants in macro.v:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO (3-bit).
  - Default latency values.
- One natural sub-module: mdu_calc, combinational. Inputs: op, A, B. Outputs: 64-bit {hi,lo} result and div_zero flag. It holds all signed/unsigned arithmetic and edge-case rules.
- mips_mdu holds the state, counter and HI/LO registers.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE(−2) B=3: busy high cycles 1..5 after start; on cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=−7 (0xFFFFFFF9), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2: LO=3, HI=1.
- MTHI A=0x12345678 then next-cycle MTLO A=0x9ABCDEF0: HI/LO update on the edge following each start; busy never rises.
- DIV B=0 with HI=0x11, LO=0x22 preloaded: busy for 10 cycles, HI=0x11 and LO=0x22 afterwards. DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Assert reset at cycle 3 of a DIV: next cycle busy=0, HI=LO=0, and no late commit occurs during the following 10 cycles.
- During busy, pulse start with MTLO A=5: LO is unchanged, and the in-flight MULT result commits normally at the end of the count.
